// File: rtl/cmam_nch.sv
`default_nettype none
// cmam_nch -- register-bus to multi-channel NMIC serial bridge with command/response FIFOs.
// Rev 1.0
module cmam_nch #(
  parameter int N_CH    = 2,
  parameter int CMD_W   = 32,
  parameter int RSP_W   = 32,
  parameter int CFIFO_D = 8,
  parameter int RFIFO_D = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [6:0]        addr,
  input  logic [31:0]       data_wr,
  input  logic              wren,
  input  logic              rden,
  output logic [31:0]       data_rd,
  input  logic [N_CH-1:0]   n2c_data,
  output logic [N_CH-1:0]   c2n_data,
  output logic [N_CH-1:0]   c2n_vld,
  output logic              irq,
  output logic              debug
);
  localparam int CA    = $clog2(CFIFO_D);
  localparam int RA    = $clog2(RFIFO_D);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int CNT_W = 6;
  localparam int CE_W  = CMD_W + 4;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_WAIT, S_CAPT} state_t;
  state_t state;

  logic             bcast, tmo, rsp_ovf, cmd_ovf;
  logic [2:0]       ch_sel;
  logic [CE_W-1:0]  cmem [CFIFO_D];
  logic [CA-1:0]    cwp, crp;
  logic [CA:0]      ccnt;
  logic [RSP_W-1:0] rmem [RFIFO_D];
  logic [RA-1:0]    rwp, rrp;
  logic [RA:0]      rcnt;
  logic [CMD_W-1:0] cur_cmd;
  logic [2:0]       cur_ch;
  logic             cur_bc;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0]    timer;
  logic [RSP_W-1:0] rsp_sr, rsp_next;
  logic [N_CH-1:0]  lane_mask, lanes;
  logic             rx_bit;
  logic             wr_cmd, wr_ctrl, wr_stat, rd_rsp;
  logic             cmd_full, cmd_empty, rsp_full, rsp_empty;
  logic             cpush, cpop, rpush_req, rpush, rpop, tmo_set;
  logic [31:0]      ctrl_val, stat_val;

  assign wr_cmd  = wren && (addr == 7'h00);
  assign wr_ctrl = wren && (addr == 7'h01);
  assign wr_stat = wren && (addr == 7'h03);
  assign rd_rsp  = rden && (addr == 7'h02);

  // Depths are powers of two, so the count MSB alone marks full.
  assign cmd_full  = ccnt[CA];
  assign cmd_empty = (ccnt == '0);
  assign rsp_full  = rcnt[RA];
  assign rsp_empty = (rcnt == '0);

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign lane_mask[i] = (cur_ch == 3'(i));
  end
  assign lanes    = cur_bc ? {N_CH{1'b1}} : lane_mask;
  assign rx_bit   = |(n2c_data & lane_mask);
  assign rsp_next = (rsp_sr << 1) | RSP_W'(rx_bit);

  assign cpush     = wr_cmd && !cmd_full;
  assign cpop      = (state == S_IDLE) && !cmd_empty;
  assign rpush_req = (state == S_CAPT) && (cnt == CNT_W'(RSP_W - 1));
  assign rpush     = rpush_req && !rsp_full;
  assign rpop      = rd_rsp && !rsp_empty;
  assign tmo_set   = (state == S_WAIT) && !rx_bit && (timer == TW'(TIMEOUT - 1));

  assign ctrl_val = {23'd0, bcast, 5'd0, ch_sel};
  assign stat_val = {8'd0, 8'(rcnt), 8'(ccnt), cmd_ovf, rsp_ovf, tmo,
                     (state != S_IDLE), rsp_full, rsp_empty, cmd_empty, cmd_full};

  assign irq   = !rsp_empty || tmo || rsp_ovf || cmd_ovf;
  assign debug = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (cpush) cmem[cwp] <= {bcast, ch_sel, data_wr[CMD_W-1:0]};
    if (rpush) rmem[rwp] <= rsp_next;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cwp <= '0; crp <= '0; ccnt <= '0;
      rwp <= '0; rrp <= '0; rcnt <= '0;
      bcast <= 1'b0; ch_sel <= 3'd0;
      tmo <= 1'b0; rsp_ovf <= 1'b0; cmd_ovf <= 1'b0;
      data_rd <= '0;
    end else begin
      if (cpush) cwp <= cwp + 1'b1;
      if (cpop)  crp <= crp + 1'b1;
      case ({cpush, cpop})
        2'b10:   ccnt <= ccnt + 1'b1;
        2'b01:   ccnt <= ccnt - 1'b1;
        default: ccnt <= ccnt;
      endcase
      if (rpush) rwp <= rwp + 1'b1;
      if (rpop)  rrp <= rrp + 1'b1;
      case ({rpush, rpop})
        2'b10:   rcnt <= rcnt + 1'b1;
        2'b01:   rcnt <= rcnt - 1'b1;
        default: rcnt <= rcnt;
      endcase
      if (wr_ctrl) begin
        bcast <= data_wr[8];
        if ({29'd0, data_wr[2:0]} < N_CH) ch_sel <= data_wr[2:0];
      end
      // A new error in the same cycle as its clear keeps the bit set.
      tmo     <= tmo_set                 | (tmo     & ~(wr_stat & data_wr[5]));
      rsp_ovf <= (rpush_req && rsp_full) | (rsp_ovf & ~(wr_stat & data_wr[6]));
      cmd_ovf <= (wr_cmd && cmd_full)    | (cmd_ovf & ~(wr_stat & data_wr[7]));
      if (rden) begin
        case (addr)
          7'h01:   data_rd <= ctrl_val;
          7'h02:   data_rd <= rsp_empty ? 32'd0 : 32'(rmem[rrp]);
          7'h03:   data_rd <= stat_val;
          default: data_rd <= 32'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= S_IDLE;
      cur_cmd  <= '0;
      cur_ch   <= 3'd0;
      cur_bc   <= 1'b0;
      cnt      <= '0;
      timer    <= '0;
      rsp_sr   <= '0;
      c2n_data <= '0;
      c2n_vld  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          c2n_data <= '0;
          c2n_vld  <= '0;
          if (!cmd_empty) begin
            {cur_bc, cur_ch, cur_cmd} <= cmem[crp];
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          c2n_vld  <= lanes;
          c2n_data <= cur_cmd[CMD_W-1] ? lanes : '0;
          cur_cmd  <= cur_cmd << 1;
          cnt      <= '0;
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == CNT_W'(CMD_W - 1)) begin
            c2n_vld  <= '0;
            c2n_data <= '0;
            timer    <= '0;
            state    <= cur_bc ? S_IDLE : S_WAIT;
          end else begin
            c2n_data <= cur_cmd[CMD_W-1] ? lanes : '0;
            cur_cmd  <= cur_cmd << 1;
            cnt      <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (rx_bit) begin
            cnt   <= '0;
            state <= S_CAPT;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CAPT: begin
          rsp_sr <= rsp_next;
          if (cnt == CNT_W'(RSP_W - 1)) state <= S_IDLE;
          else                          cnt   <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
